// File: rtl/fp_pkg.sv
// Shared floating-point types and helpers for the divider datapath.
// Class enum, exception flag bundle, divider FSM states, bias/qNaN helpers.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef struct packed {
        logic invalid;
        logic div_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_ROUND,
        S_DONE
    } fdiv_state_e;

    // exp==0 covers subnormals too: they are flushed to zero.
    function automatic fp_class_e fp_classify(
        input logic exp_ones,
        input logic exp_zero,
        input logic frac_zero
    );
        if (exp_zero) return FP_ZERO;
        if (exp_ones) return frac_zero ? FP_INF : FP_NAN;
        return FP_NORM;
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_emax(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Canonical quiet NaN: exponent all ones, fraction MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << (exp_w + 1)) - 64'd1) << (man_w - 1);
        return v;
    endfunction

endpackage

// File: rtl/fdiv_mant_core.sv
// Radix-2 non-restoring mantissa divider, one quotient bit per cycle.
// Ports: start loads divisor/dividend; quotient, sticky; done = last step.
module fdiv_mant_core
    import fp_pkg::*;
#(
    parameter int MAN_W = 23,
    localparam int Q_W = MAN_W + 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MAN_W:0]   divisor,
    input  logic [MAN_W:0]   dividend,
    output logic [Q_W-1:0]   quotient,
    output logic             sticky,
    output logic             done
);

    localparam int R_W = MAN_W + 4;
    localparam int C_W = $clog2(Q_W + 1);

    logic signed [R_W-1:0] rem;
    logic signed [R_W-1:0] d;
    logic signed [R_W-1:0] sh;
    logic signed [R_W-1:0] t;
    logic [MAN_W:0]        d_q;
    logic [C_W-1:0]        cnt;

    assign d = $signed({3'b000, d_q});

    // First step uses the dividend at weight 1, later steps shift first.
    // A negative partial remainder adds the divisor back instead of restoring.
    always_comb begin
        sh = (cnt == C_W'(Q_W)) ? rem : (rem <<< 1);
        t  = rem[R_W-1] ? (sh + d) : (sh - d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            d_q      <= '0;
            quotient <= '0;
            cnt      <= '0;
        end else if (start) begin
            rem      <= $signed({3'b000, dividend});
            d_q      <= divisor;
            quotient <= '0;
            cnt      <= C_W'(Q_W);
        end else if (cnt != '0) begin
            rem      <= t;
            quotient <= {quotient[Q_W-2:0], ~t[R_W-1]};
            cnt      <= cnt - C_W'(1);
        end
    end

    assign done = (cnt == C_W'(1));

    // Negative remainder is corrected by one divisor before the zero test.
    assign sticky = rem[R_W-1] ? ((rem + d) != '0) : (rem != '0);

endmodule

// File: rtl/fdiv_seq.sv
// Iterative IEEE-754 divider out = a / b with valid/ready on both sides.
// Ports: in_valid/in_ready/a/b in; out_valid/out_ready/out (+flags with FDIV_FLAGS_EN).
module fdiv_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int N = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out
`ifdef FDIV_FLAGS_EN
    ,
    output logic [4:0]   flags
`endif
);

    localparam int Q_W = MAN_W + 3;
    localparam int E_W = EXP_W + 2;
    localparam logic signed [E_W-1:0] E_BIAS = E_W'(fp_bias(EXP_W));
    localparam logic signed [E_W-1:0] E_MAX  = E_W'(fp_emax(EXP_W));
    localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
    localparam logic [N-1:0]          QNAN   = N'(fp_qnan(EXP_W, MAN_W));

    fdiv_state_e state_q, state_d;

    logic [N-1:0]          a_q, b_q;
    logic signed [E_W-1:0] e_q;
    logic                  sign_q, spec_q;

    logic                  core_start, core_done, core_sticky;
    logic [Q_W-1:0]        core_quo;

    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      fa, fb;
    fp_class_e             ca, cb;

    assign ea = a_q[N-2:MAN_W];
    assign eb = b_q[N-2:MAN_W];
    assign fa = a_q[MAN_W-1:0];
    assign fb = b_q[MAN_W-1:0];
    assign ca = fp_classify(&ea, ~|ea, ~|fa);
    assign cb = fp_classify(&eb, ~|eb, ~|fb);

    logic                  sign, is_nan, is_inf, is_zero, special;
    logic [N-1:0]          spec_res;
    logic signed [E_W-1:0] e_calc;

    always_comb begin
        sign    = a_q[N-1] ^ b_q[N-1];
        e_calc  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS;
        is_nan  = (ca == FP_NAN) || (cb == FP_NAN)
               || (ca == FP_ZERO && cb == FP_ZERO)
               || (ca == FP_INF && cb == FP_INF);
        is_inf  = (ca == FP_INF) || (cb == FP_ZERO);
        is_zero = (ca == FP_ZERO) || (cb == FP_INF);
        special = is_nan || is_inf || is_zero;
        spec_res = '0;
        if (is_nan)
            spec_res = QNAN;
        else if (is_inf)
            spec_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (is_zero)
            spec_res = {sign, {(N-1){1'b0}}};
    end

    logic [Q_W-1:0]        norm;
    logic signed [E_W-1:0] e1, e2;
    logic [MAN_W-1:0]      frac;
    logic [MAN_W:0]        frac_r;
    logic                  rnd_g, rnd_r, rnd_up, ovf, unf;
    logic [N-1:0]          rnd_res;

    // Quotient lies in (0.5, 2); normalise to MSB set, then RNE.
    always_comb begin
        norm   = core_quo[Q_W-1] ? core_quo : (core_quo << 1);
        e1     = core_quo[Q_W-1] ? e_q : (e_q - E_ONE);
        frac   = norm[Q_W-2:2];
        rnd_g  = norm[1];
        rnd_r  = norm[0];
        rnd_up = rnd_g & (rnd_r | core_sticky | frac[0]);
        frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
        e2     = frac_r[MAN_W] ? (e1 + E_ONE) : e1;
        ovf    = (e2 >= E_MAX);
        unf    = e2[E_W-1] || (e2 == '0);
        if (ovf)
            rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (unf)
            rnd_res = {sign_q, {(N-1){1'b0}}};
        else
            rnd_res = {sign_q, e2[EXP_W-1:0], frac_r[MAN_W-1:0]};
    end

    fdiv_mant_core #(
        .MAN_W (MAN_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (core_start),
        .divisor  ({1'b1, fb}),
        .dividend ({1'b1, fa}),
        .quotient (core_quo),
        .sticky   (core_sticky),
        .done     (core_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Special results still pass through ROUND so every result
    // reaches DONE from one state; ROUND leaves them untouched.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        core_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_PREP;
            end
            S_PREP: begin
                core_start = 1'b1;
                state_d    = special ? S_ROUND : S_ITER;
            end
            S_ITER: begin
                if (core_done) state_d = S_ROUND;
            end
            S_ROUND: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            e_q    <= '0;
            sign_q <= 1'b0;
            spec_q <= 1'b0;
            out    <= '0;
        end else begin
            if (in_valid && in_ready) begin
                a_q <= a;
                b_q <= b;
            end
            if (state_q == S_PREP) begin
                e_q    <= e_calc;
                sign_q <= sign;
                spec_q <= special;
                if (special) out <= spec_res;
            end
            if (state_q == S_ROUND && !spec_q)
                out <= rnd_res;
        end
    end

`ifdef FDIV_FLAGS_EN
    fp_flags_t flags_q, spec_flags, rnd_flags;

    // Quiet NaN inputs propagate silently; signalling ones raise invalid.
    always_comb begin
        spec_flags          = '0;
        spec_flags.invalid  = (ca == FP_ZERO && cb == FP_ZERO)
                           || (ca == FP_INF && cb == FP_INF)
                           || (ca == FP_NAN && !fa[MAN_W-1])
                           || (cb == FP_NAN && !fb[MAN_W-1]);
        spec_flags.div_zero = (ca == FP_NORM) && (cb == FP_ZERO);
        rnd_flags           = '0;
        rnd_flags.overflow  = ovf;
        rnd_flags.underflow = unf;
        rnd_flags.inexact   = rnd_g | rnd_r | core_sticky | ovf | unf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (in_valid && in_ready) begin
            flags_q <= '0;
        end else if (state_q == S_PREP && special) begin
            flags_q <= spec_flags;
        end else if (state_q == S_ROUND && !spec_q) begin
            flags_q <= rnd_flags;
        end
    end

    assign flags = flags_q;
`endif

endmodule
